// File: rtl/pattern_pkg.sv
// Shared types for the pattern timing/config block: mode and delta encodings,
// the configuration record, the sequencer state, and the config legality check.
package pattern_pkg;

    typedef enum logic [2:0] {
        MODE_NONE  = 3'b000,
        REGULAR    = 3'b001,
        CONST_MODE = 3'b010,
        H_STRIPE   = 3'b011,
        V_STRIPE   = 3'b100,
        CHECKER    = 3'b101,
        DIAG_MODE  = 3'b110,
        RAMP_MODE  = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        DX_ZERO  = 2'b00,
        DX_ONE   = 2'b01,
        DX_FOUR  = 2'b10,
        DX_EIGHT = 2'b11
    } dx_e;

    typedef enum logic [1:0] {
        DY_0    = 2'b00,
        DY_1    = 2'b01,
        DY_16   = 2'b10,
        DY_1290 = 2'b11
    } dy_e;

    typedef struct packed {
        mode_e       mode;
        logic [11:0] const_val;
        dx_e         x;
        dy_e         y;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LINE = 2'b01,
        GAP  = 2'b10
    } state_e;

    localparam cfg_t CFG_RESET = '{mode: REGULAR, const_val: 12'd0, x: DX_ZERO, y: DY_0};

    // REGULAR needs a full 4096-pixel line plus blanking, so short line periods cannot host it.
    function automatic logic cfg_mode_ok(input mode_e mode, input int line_period,
                                         input int regular_min);
        return (mode != MODE_NONE) && !((mode == REGULAR) && (line_period < regular_min));
    endfunction

endpackage

// File: rtl/pattern_sync_timing_gen_if.sv
// Control/config inputs and timing/active-config outputs of the pattern timing generator.
// master = controller side, slave = the timing generator.
interface pattern_sync_timing_gen_if;
    logic        start;
    logic        stop;
    logic        continuous;
    logic        cfg_wr;
    logic [2:0]  cfg_mode;
    logic [11:0] cfg_const;
    logic [1:0]  cfg_x;
    logic [1:0]  cfg_y;
    logic        cfg_err;
    logic        f_sync;
    logic        sync;
    logic [2:0]  Mode;
    logic [11:0] constVal;
    logic [1:0]  X;
    logic [1:0]  Y;
    logic [4:0]  line_idx;
    logic        busy;
    logic        frame_done;

    modport master (
        output start, stop, continuous, cfg_wr, cfg_mode, cfg_const, cfg_x, cfg_y,
        input  cfg_err, f_sync, sync, Mode, constVal, X, Y, line_idx, busy, frame_done
    );

    modport slave (
        input  start, stop, continuous, cfg_wr, cfg_mode, cfg_const, cfg_x, cfg_y,
        output cfg_err, f_sync, sync, Mode, constVal, X, Y, line_idx, busy, frame_done
    );
endinterface

// File: rtl/pattern_cfg_shadow.sv
// Validates config writes into a shadow register and copies it to the active set on i_load.
// Latency: one cycle for shadow update, cfg_err and active load; writes are never stalled.
module pattern_cfg_shadow
    import pattern_pkg::*;
#(
    parameter int LINE_PERIOD        = 4160,
    parameter int REGULAR_MIN_PERIOD = 4100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_cfg_wr,
    input  cfg_t i_cfg,
    input  logic i_load,
    output cfg_t o_active,
    output logic o_cfg_err
);

    cfg_t r_shadow;
    cfg_t r_active;
    logic r_cfg_err;
    logic w_cfg_ok;

    assign w_cfg_ok = cfg_mode_ok(i_cfg.mode, LINE_PERIOD, REGULAR_MIN_PERIOD);

    // The load samples the pre-edge shadow, so a write landing on the load edge waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= CFG_RESET;
            r_active  <= CFG_RESET;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= i_cfg_wr && !w_cfg_ok;
            if (i_cfg_wr && w_cfg_ok) begin
                r_shadow <= i_cfg;
            end
            if (i_load) begin
                r_active <= r_shadow;
            end
        end
    end

    assign o_active  = r_active;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/pattern_sync_timing_gen.sv
// Line/frame sync sequencer with frame-boundary config switch-over; sync/f_sync one cycle after start.
// No backpressure: start while busy is ignored, stop is deferred to the end of the current frame.
module pattern_sync_timing_gen
    import pattern_pkg::*;
#(
    parameter int LINE_PERIOD        = 4160,
    parameter int LINES_PER_FRAME    = 24,
    parameter int FRAME_GAP          = 16,
    parameter int REGULAR_MIN_PERIOD = 4100
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pattern_sync_timing_gen_if.slave   bus
);

    localparam int PIX_W = $clog2(LINE_PERIOD);
    localparam int GAP_W = $clog2(FRAME_GAP + 1);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(LINE_PERIOD - 1);
    localparam logic [4:0]       LINE_LAST = 5'(LINES_PER_FRAME - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(FRAME_GAP - 1);

    if (LINE_PERIOD < 1294) begin : g_chk_line_period
        $error("LINE_PERIOD must be at least 1294");
    end
    if ((LINES_PER_FRAME < 1) || (LINES_PER_FRAME > 31)) begin : g_chk_lines
        $error("LINES_PER_FRAME must be in 1..31");
    end
    if (FRAME_GAP < 1) begin : g_chk_gap
        $error("FRAME_GAP must be at least 1");
    end

    state_e           r_state,     w_state_nxt;
    logic [PIX_W-1:0] r_pix_cnt,   w_pix_nxt;
    logic [4:0]       r_line_idx,  w_line_nxt;
    logic [GAP_W-1:0] r_gap_cnt,   w_gap_nxt;
    logic             r_cont,      w_cont_nxt;
    logic             r_stop_pend, w_stop_pend_nxt;
    logic             w_stop_req;
    logic             w_frame_end;
    logic             w_sync_nxt;
    logic             w_fsync_nxt;

    logic             r_sync;
    logic             r_f_sync;
    logic             r_busy;
    logic             r_frame_done;

    cfg_t             w_cfg_req;
    cfg_t             w_active;
    logic             w_cfg_err;

    assign w_stop_req = r_stop_pend || bus.stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pix_cnt   <= '0;
            r_line_idx  <= '0;
            r_gap_cnt   <= '0;
            r_cont      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pix_cnt   <= w_pix_nxt;
            r_line_idx  <= w_line_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_cont      <= w_cont_nxt;
            r_stop_pend <= w_stop_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pix_nxt       = r_pix_cnt;
        w_line_nxt      = r_line_idx;
        w_gap_nxt       = r_gap_cnt;
        w_cont_nxt      = r_cont;
        w_stop_pend_nxt = r_stop_pend;
        w_frame_end     = 1'b0;

        case (r_state)
            IDLE: begin
                w_stop_pend_nxt = 1'b0;
                if (bus.start && !bus.stop) begin
                    w_state_nxt = LINE;
                    w_cont_nxt  = bus.continuous;
                    w_pix_nxt   = '0;
                    w_line_nxt  = '0;
                end
            end

            LINE: begin
                w_stop_pend_nxt = w_stop_req;
                if (r_pix_cnt == PIX_LAST) begin
                    w_pix_nxt = '0;
                    if (r_line_idx == LINE_LAST) begin
                        w_frame_end = 1'b1;
                        w_line_nxt  = '0;
                        if (r_cont && !w_stop_req) begin
                            w_state_nxt = GAP;
                            w_gap_nxt   = '0;
                        end else begin
                            w_state_nxt     = IDLE;
                            w_stop_pend_nxt = 1'b0;
                        end
                    end else begin
                        w_line_nxt = r_line_idx + 5'd1;
                    end
                end else begin
                    w_pix_nxt = r_pix_cnt + 1'b1;
                end
            end

            GAP: begin
                w_stop_pend_nxt = w_stop_req;
                if (r_gap_cnt == GAP_LAST) begin
                    if (w_stop_req) begin
                        w_state_nxt     = IDLE;
                        w_stop_pend_nxt = 1'b0;
                    end else begin
                        w_state_nxt = LINE;
                        w_pix_nxt   = '0;
                        w_line_nxt  = '0;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pulses are decoded from next-state so they land in the first cycle of the new line.
    assign w_sync_nxt  = (w_state_nxt == LINE) && (w_pix_nxt == '0);
    assign w_fsync_nxt = w_sync_nxt && (w_line_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync       <= 1'b0;
            r_f_sync     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync       <= w_sync_nxt;
            r_f_sync     <= w_fsync_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            r_frame_done <= w_frame_end;
        end
    end

    assign w_cfg_req = '{mode:      mode_e'(bus.cfg_mode),
                         const_val: bus.cfg_const,
                         x:         dx_e'(bus.cfg_x),
                         y:         dy_e'(bus.cfg_y)};

    pattern_cfg_shadow #(
        .LINE_PERIOD        (LINE_PERIOD),
        .REGULAR_MIN_PERIOD (REGULAR_MIN_PERIOD)
    ) u_cfg_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cfg_wr  (bus.cfg_wr),
        .i_cfg     (w_cfg_req),
        .i_load    (w_fsync_nxt),
        .o_active  (w_active),
        .o_cfg_err (w_cfg_err)
    );

    assign bus.cfg_err    = w_cfg_err;
    assign bus.f_sync     = r_f_sync;
    assign bus.sync       = r_sync;
    assign bus.Mode       = w_active.mode;
    assign bus.constVal   = w_active.const_val;
    assign bus.X          = w_active.x;
    assign bus.Y          = w_active.y;
    assign bus.line_idx   = r_line_idx;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_pattern_sync_timing_gen.sv
// Directed bench for pattern_sync_timing_gen on a short-line build (1300 cycles x 3 lines, gap 16).
// Event times are edge counts: an output registered at edge N is seen at the following negedge with cyc == N.
module tb_pattern_sync_timing_gen;

    localparam int LP    = 1300;
    localparam int NL    = 3;
    localparam int FG    = 16;
    localparam int FRAME = LP * NL;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    pattern_sync_timing_gen_if pif ();

    pattern_sync_timing_gen #(
        .LINE_PERIOD        (LP),
        .LINES_PER_FRAME    (NL),
        .FRAME_GAP          (FG),
        .REGULAR_MIN_PERIOD (4100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (pif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   sync_t [64];
    int   fs_t   [64];
    int   fd_t   [64];
    logic fd_busy[64];
    logic fd_prev[64];
    int   n_sync = 0;
    int   n_fs   = 0;
    int   n_fd   = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        prev_busy <= pif.busy;
        if (pif.sync && n_sync < 64) begin
            sync_t[n_sync] <= cyc;
            n_sync         <= n_sync + 1;
        end
        if (pif.f_sync && n_fs < 64) begin
            fs_t[n_fs] <= cyc;
            n_fs       <= n_fs + 1;
        end
        if (pif.frame_done && n_fd < 64) begin
            fd_t[n_fd]    <= cyc;
            fd_busy[n_fd] <= pif.busy;
            fd_prev[n_fd] <= prev_busy;
            n_fd          <= n_fd + 1;
        end
    end

    int n_vec     = 0;
    int n_miscmp  = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_start(input logic cont, output int e);
        pif.continuous = cont;
        pif.start      = 1'b1;
        e              = cyc + 1;
        @(negedge clk);
        pif.start      = 1'b0;
    endtask

    task automatic pulse_stop();
        pif.stop = 1'b1;
        @(negedge clk);
        pif.stop = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] m, input logic [11:0] c,
                             input logic [1:0] x, input logic [1:0] y);
        pif.cfg_wr    = 1'b1;
        pif.cfg_mode  = m;
        pif.cfg_const = c;
        pif.cfg_x     = x;
        pif.cfg_y     = y;
    endtask

    initial begin
        int e, bs, bf, bd;
        rst_n          = 1'b0;
        pif.start      = 1'b0;
        pif.stop       = 1'b0;
        pif.continuous = 1'b0;
        pif.cfg_wr     = 1'b0;
        pif.cfg_mode   = 3'd0;
        pif.cfg_const  = 12'd0;
        pif.cfg_x      = 2'd0;
        pif.cfg_y      = 2'd0;
        repeat (3) @(negedge clk);

        chk_eq("rst_sync",       pif.sync,       0);
        chk_eq("rst_f_sync",     pif.f_sync,     0);
        chk_eq("rst_busy",       pif.busy,       0);
        chk_eq("rst_frame_done", pif.frame_done, 0);
        chk_eq("rst_cfg_err",    pif.cfg_err,    0);
        chk_eq("rst_line_idx",   pif.line_idx,   0);
        chk_eq("rst_mode",       pif.Mode,       1);
        chk_eq("rst_const",      pif.constVal,   0);
        chk_eq("rst_x",          pif.X,          0);
        chk_eq("rst_y",          pif.Y,          0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame with defaults.
        bs = n_sync; bf = n_fs; bd = n_fd;
        do_start(1'b0, e);
        chk_eq("t1_fsync_first", pif.f_sync, 1);
        chk_eq("t1_sync_first",  pif.sync,   1);
        wait_cyc(e + 2 * LP + 10);
        chk_eq("t1_line_idx2",   pif.line_idx, 2);
        chk_eq("t1_busy_mid",    pif.busy,     1);
        wait_cyc(e + FRAME + 5);
        chk_eq("t1_sync_count",  n_sync - bs,  NL);
        chk_eq("t1_sync0",       sync_t[bs],     e);
        chk_eq("t1_sync1",       sync_t[bs + 1], e + LP);
        chk_eq("t1_sync2",       sync_t[bs + 2], e + 2 * LP);
        chk_eq("t1_fsync_count", n_fs - bf,    1);
        chk_eq("t1_fd_count",    n_fd - bd,    1);
        chk_eq("t1_fd_time",     fd_t[bd],     e + FRAME);
        chk_eq("t1_busy_at_fd",  fd_busy[bd],  0);
        chk_eq("t1_busy_pre_fd", fd_prev[bd],  1);

        // start and stop together in IDLE is a no-op.
        bs = n_sync;
        pif.start = 1'b1;
        pif.stop  = 1'b1;
        @(negedge clk);
        pif.start = 1'b0;
        pif.stop  = 1'b0;
        repeat (50) @(negedge clk);
        chk_eq("t5_startstop_nosync", n_sync - bs, 0);
        chk_eq("t5_startstop_idle",   pif.busy,    0);

        // start while busy is ignored, including its continuous level.
        bs = n_sync; bf = n_fs; bd = n_fd;
        do_start(1'b0, e);
        wait_cyc(e + 500);
        pif.continuous = 1'b1;
        pif.start      = 1'b1;
        @(negedge clk);
        pif.start      = 1'b0;
        wait_cyc(e + FRAME + 100);
        chk_eq("t5_busy_sync_count", n_sync - bs,    NL);
        chk_eq("t5_busy_sync1",      sync_t[bs + 1], e + LP);
        chk_eq("t5_busy_fsync_cnt",  n_fs - bf,      1);
        chk_eq("t5_busy_fd_time",    fd_t[bd],       e + FRAME);
        chk_eq("t5_busy_end_idle",   pif.busy,       0);

        // Continuous frames, stop issued mid-line 1 of frame 2.
        bs = n_sync; bf = n_fs; bd = n_fd;
        do_start(1'b1, e);
        wait_cyc(e + FRAME + FG + LP + 500);
        pulse_stop();
        wait_cyc(e + 2 * FRAME + FG + 200);
        chk_eq("t2_fsync_count",  n_fs - bf,      2);
        chk_eq("t2_fsync2_time",  fs_t[bf + 1],   e + FRAME + FG);
        chk_eq("t2_fd_count",     n_fd - bd,      2);
        chk_eq("t2_fd1_time",     fd_t[bd],       e + FRAME);
        chk_eq("t2_fd2_time",     fd_t[bd + 1],   e + 2 * FRAME + FG);
        chk_eq("t2_busy_gap",     fd_busy[bd],    1);
        chk_eq("t2_busy_fd2",     fd_busy[bd + 1], 0);
        chk_eq("t2_sync_count",   n_sync - bs,    2 * NL);
        chk_eq("t2_last_sync",    sync_t[bs + 5], e + FRAME + FG + 2 * LP);
        chk_eq("t2_end_idle",     pif.busy,       0);

        // Rejected writes: mode 000, and REGULAR on a 1300-cycle line.
        cfg_write(3'b000, 12'h123, 2'd3, 2'd3);
        @(negedge clk);
        chk_eq("t3_err_mode0", pif.cfg_err, 1);
        pif.cfg_mode = 3'b001;
        @(negedge clk);
        chk_eq("t3_err_regular", pif.cfg_err, 1);
        pif.cfg_wr = 1'b0;
        @(negedge clk);
        chk_eq("t3_err_one_cycle", pif.cfg_err, 0);
        do_start(1'b0, e);
        chk_eq("t3_fsync",       pif.f_sync,   1);
        chk_eq("t3_mode_kept",   pif.Mode,     1);
        chk_eq("t3_const_kept",  pif.constVal, 0);
        chk_eq("t3_x_kept",      pif.X,        0);
        cfg_write(3'b010, 12'hABC, 2'd1, 2'd2);
        @(negedge clk);
        pif.cfg_wr = 1'b0;
        chk_eq("t3_valid_no_err", pif.cfg_err, 0);
        repeat (5) @(negedge clk);
        chk_eq("t3_mode_not_live", pif.Mode, 1);
        wait_cyc(e + FRAME + 50);

        // Mid-frame write applies at the next f_sync; a write on the load edge waits another frame.
        do_start(1'b1, e);
        chk_eq("t4_mode_f1",  pif.Mode,     2);
        chk_eq("t4_const_f1", pif.constVal, 12'hABC);
        chk_eq("t4_x_f1",     pif.X,        1);
        chk_eq("t4_y_f1",     pif.Y,        2);
        wait_cyc(e + LP + 200);
        cfg_write(3'b111, 12'h3C3, 2'd2, 2'd3);
        @(negedge clk);
        pif.cfg_wr = 1'b0;
        repeat (3) @(negedge clk);
        chk_eq("t4_mode_held_mid", pif.Mode, 2);
        wait_cyc(e + FRAME + FG - 1);
        chk_eq("t4_mode_before_fs", pif.Mode, 2);
        cfg_write(3'b011, 12'h055, 2'd0, 2'd1);
        @(negedge clk);
        pif.cfg_wr = 1'b0;
        chk_eq("t4_fsync2",   pif.f_sync,   1);
        chk_eq("t4_mode_f2",  pif.Mode,     7);
        chk_eq("t4_const_f2", pif.constVal, 12'h3C3);
        chk_eq("t4_x_f2",     pif.X,        2);
        chk_eq("t4_y_f2",     pif.Y,        3);
        wait_cyc(e + 2 * (FRAME + FG));
        chk_eq("t4_fsync3",   pif.f_sync,   1);
        chk_eq("t4_mode_f3",  pif.Mode,     3);
        chk_eq("t4_const_f3", pif.constVal, 12'h055);
        chk_eq("t4_y_f3",     pif.Y,        1);
        pulse_stop();
        wait_cyc(e + 3 * FRAME + 2 * FG + 100);
        chk_eq("t4_end_idle", pif.busy, 0);

        // Asynchronous reset in the middle of line 2.
        do_start(1'b0, e);
        wait_cyc(e + 2 * LP + 300);
        chk_eq("t6_busy_before", pif.busy, 1);
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_busy",  pif.busy,     0);
        chk_eq("t6_rst_line",  pif.line_idx, 0);
        chk_eq("t6_rst_mode",  pif.Mode,     1);
        chk_eq("t6_rst_const", pif.constVal, 0);
        chk_eq("t6_rst_y",     pif.Y,        0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bs = n_sync;
        repeat (2000) @(negedge clk);
        chk_eq("t6_no_sync_after_rst", n_sync - bs, 0);
        do_start(1'b0, e);
        chk_eq("t6_restart_fsync", pif.f_sync, 1);
        chk_eq("t6_restart_sync",  pif.sync,   1);
        chk_eq("t6_restart_mode",  pif.Mode,   1);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
